// File: rtl/regfile_2r1w.sv
// 2**ADDR_W x DATA_W register file: one synchronous write port, two combinational read ports, r0 hardwired to zero.
// Optional write-through forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              clrn_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wn_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic [ADDR_W-1:0] rna_i,
  input  logic [ADDR_W-1:0] rnb_i,
  output logic [DATA_W-1:0] qa_o,
  output logic [DATA_W-1:0] qb_o
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0]  wordEn;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] storeA;
  logic [DATA_W-1:0] storeB;

  // One-hot word enables; word 0 never gets one, which keeps r0 at zero.
  always_comb begin
    wordEn = '0;
    if (we_i) begin
      wordEn[wn_i] = 1'b1;
    end
    wordEn[0] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = wordEn[i] ? d_i : regs_q[i];
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    storeA = (rna_i == '0) ? '0 : regs_q[rna_i];
    storeB = (rnb_i == '0) ? '0 : regs_q[rnb_i];
  end

`ifdef REGFILE_BYPASS_EN
  // Forward writeback data; wordEn[0] is always low, so reads of r0 stay zero.
  always_comb begin
    qa_o = (clrn_i && wordEn[rna_i]) ? d_i : storeA;
    qb_o = (clrn_i && wordEn[rnb_i]) ? d_i : storeB;
  end
`else
  always_comb begin
    qa_o = storeA;
    qb_o = storeB;
  end
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed cases followed by randomized traffic,
// checked against an array model of the register file (honours REGFILE_BYPASS_EN).
module tb_regfile_2r1w;

  logic        clk;
  logic        clrn;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] qa;
  logic [31:0] qb;

  logic [31:0] model [32];
  int testsRun;
  int failCount;

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i (clk),
    .clrn_i(clrn),
    .we_i  (we),
    .wn_i  (wn),
    .d_i   (d),
    .rna_i (rna),
    .rnb_i (rnb),
    .qa_o  (qa),
    .qb_o  (qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value from the model, including same-cycle forwarding when enabled.
  function automatic logic [31:0] expQ(input logic [4:0] rn);
    if (rn == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we === 1'b1 && clrn === 1'b1 && wn != 5'd0 && rn == wn) return d;
`endif
    return model[rn];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic applyStimulus(input logic weV, input logic [4:0] wnV, input logic [31:0] dV);
    @(negedge clk);
    we = weV;
    wn = wnV;
    d  = dV;
  endtask

  task automatic tick();
    @(posedge clk);
    if (clrn === 1'b1 && we === 1'b1 && wn != 5'd0) model[wn] = d;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] a, input logic [4:0] b);
    logic [31:0] ea;
    logic [31:0] eb;
    rna = a;
    rnb = b;
    #1;
    ea = expQ(a);
    eb = expQ(b);
    testsRun++;
    assert (qa === ea) else begin
      failCount++;
      $error("[TB] FAIL %s qa(rna=%0d): got %h expected %h", tag, a, qa, ea);
    end
    testsRun++;
    assert (qb === eb) else begin
      failCount++;
      $error("[TB] FAIL %s qb(rnb=%0d): got %h expected %h", tag, b, qb, eb);
    end
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    clrn = 1'b0;
    we   = 1'b0;
    wn   = '0;
    d    = '0;
    rna  = '0;
    rnb  = '0;
    clearModel();
    #12 clrn = 1'b1;
    checkOutput("reset_state", 5'd1, 5'd31);

    // Asynchronous clear mid-cycle wipes a preloaded register with no edge.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("preload_r5", 5'd5, 5'd5);
    #1 clrn = 1'b0;
    clearModel();
    checkOutput("async_clear_r5", 5'd5, 5'd5);
    for (int i = 0; i < 32; i++) checkOutput("clear_all", 5'(i), 5'(31 - i));
    @(negedge clk);
    clrn = 1'b1;

    applyStimulus(1'b1, 5'd3, 32'h12345678);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("write_r3", 5'd3, 5'd3);
    checkOutput("r4_untouched", 5'd4, 5'd4);

    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF);
    checkOutput("r0_write_pre", 5'd0, 5'd0);
    tick();
    checkOutput("r0_write_post", 5'd0, 5'd3);

    applyStimulus(1'b1, 5'd7, 32'h00000011);
    tick();
    applyStimulus(1'b0, 5'd7, 32'hA5A5A5A5);
    tick();
    checkOutput("we_low_r7", 5'd7, 5'd7);

    // Same-cycle read of the register being written.
    applyStimulus(1'b1, 5'd9, 32'h1);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h2);
    checkOutput("hazard_pre", 5'd9, 5'd3);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("hazard_post", 5'd9, 5'd9);

    // Write requested while reset is held is discarded; honoured after release.
    @(negedge clk);
    clrn = 1'b0;
    clearModel();
    applyStimulus(1'b1, 5'd12, 32'h55);
    checkOutput("rst_vs_wr_pre", 5'd12, 5'd12);
    tick();
    checkOutput("rst_vs_wr_post", 5'd12, 5'd12);
    clrn = 1'b1;
    checkOutput("rst_release", 5'd12, 5'd9);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("first_write", 5'd12, 5'd12);

    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'b1 & ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
      checkOutput("rand_pre", 5'($urandom_range(0, 31)), (n % 4 == 0) ? wn : 5'($urandom_range(0, 31)));
      tick();
      checkOutput("rand_post", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
